// File: rtl/tinyrv1_ctrl_pkg.sv
// Shared encodings for the TinyRV1 multi-cycle control unit: FSM states, ISA fields and
// datapath select codes.
package tinyrv1_ctrl_pkg;

  typedef enum logic [2:0] {
    StFReq,
    StFWait,
    StDec,
    StExec,
    StMulW,
    StMReq,
    StMWait,
    StHalt
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'd0;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_SW   = 3'd2;
  localparam logic [2:0] F3_JR   = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;

  localparam logic [6:0] F7_ADD = 7'd0;
  localparam logic [6:0] F7_MUL = 7'd1;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_J = 2'd2;
  localparam logic [1:0] IMM_B = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_RS1   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MUL  = 2'd1;
  localparam logic [1:0] WB_DMEM = 2'd2;
  localparam logic [1:0] WB_PC4  = 2'd3;

  // One-hot instruction class; all-zero means the encoding is illegal.
  typedef struct packed {
    logic add;
    logic mul;
    logic addi;
    logic lw;
    logic sw;
    logic jal;
    logic jr;
    logic bne;
  } inst_cls_t;

endpackage

// File: rtl/tinyrv1_ctrl_fsm_if.sv
// Memory and multiplier handshakes between the control unit (master) and its servants.
interface tinyrv1_ctrl_fsm_if;

  logic imem_req_val;
  logic imem_req_rdy;
  logic imem_resp_val;
  logic dmem_req_val;
  logic dmem_req_wr;
  logic dmem_req_rdy;
  logic dmem_resp_val;
  logic mul_start;
  logic mul_done;

  modport master (
    output imem_req_val,
    input  imem_req_rdy,
    input  imem_resp_val,
    output dmem_req_val,
    output dmem_req_wr,
    input  dmem_req_rdy,
    input  dmem_resp_val,
    output mul_start,
    input  mul_done
  );

  modport slave (
    input  imem_req_val,
    output imem_req_rdy,
    output imem_resp_val,
    input  dmem_req_val,
    input  dmem_req_wr,
    output dmem_req_rdy,
    output dmem_resp_val,
    input  mul_start,
    output mul_done
  );

endinterface

// File: rtl/tinyrv1_decode.sv
// Combinational TinyRV1 decoder: IR contents to one-hot instruction class plus illegal flag.
module tinyrv1_decode
  import tinyrv1_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output inst_cls_t   cls,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_inst_bits;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  // Register and immediate fields only matter to the datapath.
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  always_comb begin
    cls = '0;
    unique case (opc)
      OPC_OP: begin
        cls.add = (f7 == F7_ADD);
        cls.mul = (f7 == F7_MUL);
      end
      OPC_OPIMM:  cls.addi = (f3 == F3_ADDI);
      OPC_LOAD:   cls.lw   = (f3 == F3_LW);
      OPC_STORE:  cls.sw   = (f3 == F3_SW);
      OPC_JAL:    cls.jal  = 1'b1;
      OPC_JALR:   cls.jr   = (f3 == F3_JR);
      OPC_BRANCH: cls.bne  = (f3 == F3_BNE);
      default: ;
    endcase
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/tinyrv1_ctrl_fsm.sv
// TinyRV1 multi-cycle control unit: sequences fetch/decode/execute/memory/writeback, drives
// datapath selects and counts retired instructions.
module tinyrv1_ctrl_fsm
  import tinyrv1_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  tinyrv1_ctrl_fsm_if.master bus,
  input  logic [31:0]        inst,
  input  logic               br_ne,
  output logic               ir_en,
  output logic               pc_en,
  output logic [1:0]         pc_sel,
  output logic [1:0]         imm_type,
  output logic               op2_sel,
  output logic [1:0]         wb_sel,
  output logic               rf_wen,
  output logic               illegal,
  output logic [CNT_W-1:0]   instret,
  output logic [31:0]        pc_reset_val
);

  state_e          state_q;
  logic            illegal_q;
  logic [CNT_W-1:0] instret_q;
  inst_cls_t       cls;
  logic            dec_illegal;
  logic            retire;

  tinyrv1_decode u_decode (
    .inst    (inst),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFReq;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      unique case (state_q)
        StFReq:  if (bus.imem_req_rdy) state_q <= StFWait;
        StFWait: if (bus.imem_resp_val) state_q <= StDec;
        StDec: begin
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= StHalt;
          end else if (cls.mul) begin
            state_q <= StMulW;
          end else if (cls.lw || cls.sw) begin
            state_q <= StMReq;
          end else begin
            state_q <= StExec;
          end
        end
        StExec:  state_q <= StFReq;
        StMulW:  if (bus.mul_done) state_q <= StFReq;
        StMReq:  if (bus.dmem_req_rdy) state_q <= StMWait;
        StMWait: if (bus.dmem_resp_val) state_q <= StFReq;
        StHalt:  state_q <= StHalt;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even though the state already reads StFReq.
  always_comb begin
    bus.imem_req_val = 1'b0;
    bus.dmem_req_val = 1'b0;
    bus.dmem_req_wr  = 1'b0;
    bus.mul_start    = 1'b0;
    ir_en            = 1'b0;
    pc_en            = 1'b0;
    pc_sel           = PC_PLUS4;
    imm_type         = IMM_I;
    op2_sel          = 1'b0;
    wb_sel           = WB_ALU;
    rf_wen           = 1'b0;
    retire           = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StFReq:  bus.imem_req_val = 1'b1;
        StFWait: ir_en = bus.imem_resp_val;
        StDec:   bus.mul_start = cls.mul & ~dec_illegal;
        StExec: begin
          pc_en  = 1'b1;
          retire = 1'b1;
          if (cls.add) begin
            rf_wen = 1'b1;
          end
          if (cls.addi) begin
            rf_wen  = 1'b1;
            op2_sel = 1'b1;
          end
          if (cls.jal) begin
            rf_wen   = 1'b1;
            wb_sel   = WB_PC4;
            imm_type = IMM_J;
            pc_sel   = PC_IMM;
          end
          if (cls.jr) begin
            pc_sel = PC_RS1;
          end
          if (cls.bne) begin
            imm_type = IMM_B;
            pc_sel   = br_ne ? PC_IMM : PC_PLUS4;
          end
        end
        StMulW: begin
          if (bus.mul_done) begin
            rf_wen = 1'b1;
            wb_sel = WB_MUL;
            pc_en  = 1'b1;
            retire = 1'b1;
          end
        end
        StMReq: begin
          bus.dmem_req_val = 1'b1;
          bus.dmem_req_wr  = cls.sw;
          op2_sel          = 1'b1;
          imm_type         = cls.sw ? IMM_S : IMM_I;
        end
        StMWait: begin
          imm_type = cls.sw ? IMM_S : IMM_I;
          if (bus.dmem_resp_val) begin
            pc_en  = 1'b1;
            retire = 1'b1;
            if (cls.lw) begin
              rf_wen = 1'b1;
              wb_sel = WB_DMEM;
            end
          end
        end
        StHalt: ;
      endcase
    end
  end

  assign illegal      = illegal_q;
  assign instret      = instret_q;
  assign pc_reset_val = RESET_PC;

endmodule

// File: tb/tb_tinyrv1_ctrl_fsm.sv
// Directed bench for tinyrv1_ctrl_fsm; a 3-bit instret makes the wrap reachable quickly.
module tb_tinyrv1_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        br_ne;
  logic        ir_en;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [1:0]  imm_type;
  logic        op2_sel;
  logic [1:0]  wb_sel;
  logic        rf_wen;
  logic        illegal;
  logic [2:0]  instret;
  logic [31:0] pc_reset_val;

  int checks = 0;
  int errors = 0;

  tinyrv1_ctrl_fsm_if bus ();

  tinyrv1_ctrl_fsm #(
    .RESET_PC (32'h0000_0200),
    .CNT_W    (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .inst         (inst),
    .br_ne        (br_ne),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .imm_type     (imm_type),
    .op2_sel      (op2_sel),
    .wb_sel       (wb_sel),
    .rf_wen       (rf_wen),
    .illegal      (illegal),
    .instret      (instret),
    .pc_reset_val (pc_reset_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From F_REQ: fetch i with nwait empty F_WAIT cycles; returns in DEC.
  task automatic fetch(input logic [31:0] i, input int nwait);
    inst = i;
    bus.imem_req_rdy  = 1'b1;
    bus.imem_resp_val = 1'b0;
    tick();
    for (int k = 0; k < nwait; k++) begin
      check("fwait_ir_en", ir_en, 1'b0);
      tick();
    end
    bus.imem_resp_val = 1'b1;
    #1;
    check("fwait_ir_en_resp", ir_en, 1'b1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    inst  = 32'h0;
    br_ne = 1'b0;
    bus.imem_req_rdy  = 1'b0;
    bus.imem_resp_val = 1'b0;
    bus.dmem_req_rdy  = 1'b0;
    bus.dmem_resp_val = 1'b0;
    bus.mul_done      = 1'b0;
    #2;
    check("rst_imem_req_val", bus.imem_req_val, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_instret", instret, 3'd0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_pc_reset_val", pc_reset_val, 32'h0000_0200);
    tick();
    rst_n = 1'b1;

    // ADDI x1,x0,5 with zero-wait memories
    inst = 32'h0050_0093;
    bus.imem_req_rdy  = 1'b1;
    bus.imem_resp_val = 1'b1;
    bus.dmem_req_rdy  = 1'b1;
    bus.dmem_resp_val = 1'b1;
    #1;
    check("addi_c1_imem_req_val", bus.imem_req_val, 1'b1);
    check("addi_c1_ir_en", ir_en, 1'b0);
    tick();
    check("addi_c2_ir_en", ir_en, 1'b1);
    check("addi_c2_imem_req_val", bus.imem_req_val, 1'b0);
    tick();
    check("addi_c3_pc_en", pc_en, 1'b0);
    check("addi_c3_rf_wen", rf_wen, 1'b0);
    tick();
    check("addi_rf_wen", rf_wen, 1'b1);
    check("addi_op2_sel", op2_sel, 1'b1);
    check("addi_imm_type", imm_type, 2'd0);
    check("addi_pc_en", pc_en, 1'b1);
    check("addi_pc_sel", pc_sel, 2'd0);
    check("addi_wb_sel", wb_sel, 2'd0);
    tick();
    check("addi_instret", instret, 3'd1);
    check("addi_next_fetch", bus.imem_req_val, 1'b1);

    // BNE taken, then not taken
    for (int t = 0; t < 2; t++) begin
      fetch(32'h0020_9463, t);
      br_ne = (t == 0);
      tick();
      check("bne_imm_type", imm_type, 2'd3);
      check("bne_pc_sel", pc_sel, (t == 0) ? 2'd1 : 2'd0);
      check("bne_pc_en", pc_en, 1'b1);
      check("bne_rf_wen", rf_wen, 1'b0);
      tick();
    end
    check("bne_instret", instret, 3'd3);

    // SW with dmem_req_rdy low for 3 cycles; early responses must be ignored
    fetch(32'h0020_a023, 0);
    bus.dmem_req_rdy  = 1'b0;
    bus.dmem_resp_val = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.dmem_req_rdy = (k == 3);
      #1;
      check("sw_req_val", bus.dmem_req_val, 1'b1);
      check("sw_req_wr", bus.dmem_req_wr, 1'b1);
      check("sw_imm_type", imm_type, 2'd1);
      check("sw_op2_sel", op2_sel, 1'b1);
      check("sw_req_pc_en", pc_en, 1'b0);
      tick();
    end
    bus.dmem_resp_val = 1'b0;
    #1;
    check("sw_wait_req_val", bus.dmem_req_val, 1'b0);
    check("sw_wait_imm_type", imm_type, 2'd1);
    check("sw_wait_pc_en", pc_en, 1'b0);
    tick();
    bus.dmem_resp_val = 1'b1;
    #1;
    check("sw_resp_rf_wen", rf_wen, 1'b0);
    check("sw_resp_pc_en", pc_en, 1'b1);
    tick();
    check("sw_instret", instret, 3'd4);

    // MUL with mul_done 8 cycles after start
    fetch(32'h0220_81b3, 0);
    check("mul_start_pulse", bus.mul_start, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      bus.mul_done = (k == 7);
      #1;
      check("mul_start_low", bus.mul_start, 1'b0);
      check("mul_rf_wen", rf_wen, k == 7);
      check("mul_wb_sel", wb_sel, (k == 7) ? 2'd1 : 2'd0);
      check("mul_pc_en", pc_en, k == 7);
      tick();
    end
    bus.mul_done = 1'b0;
    check("mul_instret", instret, 3'd5);

    // ADD, JAL, JR; the JR retirement wraps the 3-bit counter
    fetch(32'h0020_81b3, 0);
    tick();
    check("add_rf_wen", rf_wen, 1'b1);
    check("add_op2_sel", op2_sel, 1'b0);
    check("add_wb_sel", wb_sel, 2'd0);
    tick();
    fetch(32'h0080_00ef, 0);
    tick();
    check("jal_rf_wen", rf_wen, 1'b1);
    check("jal_wb_sel", wb_sel, 2'd3);
    check("jal_imm_type", imm_type, 2'd2);
    check("jal_pc_sel", pc_sel, 2'd1);
    tick();
    check("jal_instret", instret, 3'd7);
    fetch(32'h0000_8067, 0);
    tick();
    check("jr_pc_sel", pc_sel, 2'd2);
    check("jr_rf_wen", rf_wen, 1'b0);
    check("jr_pc_en", pc_en, 1'b1);
    tick();
    check("instret_wrap", instret, 3'd0);

    // Illegal instruction halts until reset
    fetch(32'hffff_ffff, 0);
    check("illegal_dec_pc_en", pc_en, 1'b0);
    check("illegal_dec_mul_start", bus.mul_start, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("halt_illegal", illegal, 1'b1);
      check("halt_imem_req_val", bus.imem_req_val, 1'b0);
      check("halt_pc_en", pc_en, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst_illegal", illegal, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("halt_rst_fetch", bus.imem_req_val, 1'b1);

    // LW interrupted by reset in M_WAIT
    fetch(32'h0001_2083, 0);
    bus.dmem_req_rdy  = 1'b1;
    bus.dmem_resp_val = 1'b0;
    tick();
    check("lw_req_imm_type", imm_type, 2'd0);
    check("lw_req_wr", bus.dmem_req_wr, 1'b0);
    check("lw_req_val", bus.dmem_req_val, 1'b1);
    tick();
    check("lw_wait_rf_wen", rf_wen, 1'b0);
    bus.dmem_resp_val = 1'b1;
    #1;
    check("lw_resp_rf_wen", rf_wen, 1'b1);
    check("lw_resp_wb_sel", wb_sel, 2'd2);
    rst_n = 1'b0;
    #1;
    check("lw_rst_rf_wen", rf_wen, 1'b0);
    check("lw_rst_pc_en", pc_en, 1'b0);
    check("lw_rst_wb_sel", wb_sel, 2'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("lw_rst_instret", instret, 3'd0);
    check("lw_rst_fetch", bus.imem_req_val, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
